// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU select codes, ALU-op classes, funct codes and the
// registered control bundle shared by the ID/EX stage.
package id_ex_stage_pkg;
  localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_ILLEGAL = 3'd3,
                         ALU_ANDN = 3'd4, ALU_ORN = 3'd5, ALU_SUB = 3'd6, ALU_SLT = 3'd7;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RTYPE = 2'b10, OP_OR = 2'b11;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;
  function automatic logic [2:0] funct_sel(input logic [5:0] f);
    return f == F_ADD ? ALU_ADD : f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND :
           f == F_OR ? ALU_OR : f == F_SLT ? ALU_SLT : ALU_ILLEGAL;
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: per-operand forwarding selector; EX/MEM beats MEM/WB,
// register 0 is never forwarded.
module id_ex_stage_fwd_mux #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] src,
  input  logic [WIDTH-1:0] reg_data,
  input  logic             mem_reg_write,
  input  logic [RADDR-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] fwd_data
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = mem_reg_write && mem_rd != '0 && mem_rd == src;
    wb_hit = wb_reg_write && wb_rd != '0 && wb_rd == src;
    fwd_data = mem_hit ? mem_result : wb_hit ? wb_data : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand
// forwarding and load-use hazard detection.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [5:0]       id_funct,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             mem_reg_write,
  input  logic [RADDR-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RADDR-1:0] ex_dest,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic             load_use_hazard
);
  ctrl_t            ctrl, id_ctrl;
  logic             valid;
  logic [WIDTH-1:0] rs_data, rt_data, imm;
  logic [RADDR-1:0] rs, rt, rd;
  logic [5:0]       funct;
  logic [2:0]       r_sel;
  assign id_ctrl = '{id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
                     id_mem_write, id_mem_to_reg, id_branch};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      {valid, ctrl, rs_data, rt_data, imm, rs, rt, rd, funct} <= '0;
    else if (flush)
      {valid, ctrl, rs_data, rt_data, imm, rs, rt, rd, funct} <= '0;
    else if (!stall)
      {valid, ctrl, rs_data, rt_data, imm, rs, rt, rd, funct} <=
        {id_valid, id_ctrl, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct};
  id_ex_stage_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
    .src(rs), .reg_data(rs_data), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_data(alu_a));
  id_ex_stage_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
    .src(rt), .reg_data(rt_data), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_data(ex_store_data));
  assign r_sel = funct_sel(funct);
  always_comb begin
    alu_sel = ctrl.alu_op == OP_ADD ? ALU_ADD : ctrl.alu_op == OP_SUB ? ALU_SUB :
              ctrl.alu_op == OP_OR ? ALU_OR : r_sel;
    ex_illegal = valid && ctrl.alu_op == OP_RTYPE && r_sel == ALU_ILLEGAL;
    alu_b = ctrl.alu_src ? imm : ex_store_data;
    ex_dest = ctrl.reg_dst ? rd : rt;
    ex_valid = valid;
    ex_reg_write = valid && ctrl.reg_write;
    ex_mem_read = valid && ctrl.mem_read;
    ex_mem_write = valid && ctrl.mem_write;
    ex_mem_to_reg = ctrl.mem_to_reg;
    ex_branch = valid && ctrl.branch;
    load_use_hazard = valid && ctrl.mem_read && rt != '0 && (rt == id_rs || rt == id_rt);
  end
endmodule
